// File: rtl/lsu_dmem_if_if.sv
// Bundle of the core-facing request/response handshake and the data-memory port.
// The slave modport is the load/store unit; the master modport is the core plus the memory.
interface lsu_dmem_if_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic [1:0]        mem_rw;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err, mem_rw, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, mem_rw, mem_addr, mem_wdata
  );
endinterface

// File: rtl/lsu_dmem_if.sv
// RV32I load/store unit driving a word-wide, byte-addressed data memory (RMW for SB/SH).
// Define LSU_MISALIGN_EN to skip alignment checks and issue unaligned word accesses directly.
module lsu_dmem_if #(
  parameter int MEM_BYTES = 80,
  parameter int ADDR_W    = 32
) (
  input  logic          clk,
  input  logic          rst,
  lsu_dmem_if_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  state_t            state_q;
  logic              we_q;
  logic [2:0]        funct3_q;
  logic [1:0]        lane_q;
  logic [15:0]       wdata_q;
  logic [1:0]        mem_rw_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [31:0]       mem_wdata_q;
  logic              resp_valid_q;
  logic [31:0]       resp_rdata_q;
  logic              resp_err_q;

  logic [ADDR_W-1:0] req_base;
  logic [1:0]        req_lane;
  logic [ADDR_W:0]   req_end;
  logic              funct3_ok;
  logic              misaligned;
  logic              out_of_range;
  logic              req_error;

  logic [7:0]        load_byte;
  logic [15:0]       load_half;
  logic [31:0]       load_data;
  logic [31:0]       merged_word;

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.mem_rw     = mem_rw_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;

  // The end address is one bit wider so a footprint wrapping past 2^ADDR_W reads as out of range.
  always_comb begin
`ifdef LSU_MISALIGN_EN
    req_base   = bus.req_addr;
    req_lane   = 2'b00;
    misaligned = 1'b0;
`else
    req_base   = {bus.req_addr[ADDR_W-1:2], 2'b00};
    req_lane   = bus.req_addr[1:0];
    misaligned = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
                 ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));
`endif
    case (bus.req_funct3)
      3'b000, 3'b001, 3'b010: funct3_ok = 1'b1;
      3'b100, 3'b101:         funct3_ok = !bus.req_we;
      default:                funct3_ok = 1'b0;
    endcase
    req_end      = {1'b0, req_base} + (ADDR_W+1)'(3);
    out_of_range = (req_end >= (ADDR_W+1)'(MEM_BYTES));
    req_error    = !funct3_ok || misaligned || out_of_range;
  end

  always_comb begin
    case (lane_q)
      2'd0:    load_byte = bus.mem_rdata[7:0];
      2'd1:    load_byte = bus.mem_rdata[15:8];
      2'd2:    load_byte = bus.mem_rdata[23:16];
      default: load_byte = bus.mem_rdata[31:24];
    endcase
    load_half = lane_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    case (funct3_q)
      3'b000:  load_data = {{24{load_byte[7]}}, load_byte};
      3'b100:  load_data = {24'h000000, load_byte};
      3'b001:  load_data = {{16{load_half[15]}}, load_half};
      3'b101:  load_data = {16'h0000, load_half};
      default: load_data = bus.mem_rdata;
    endcase
    merged_word = bus.mem_rdata;
    if (funct3_q[1:0] == 2'b00) begin
      case (lane_q)
        2'd0:    merged_word[7:0]   = wdata_q[7:0];
        2'd1:    merged_word[15:8]  = wdata_q[7:0];
        2'd2:    merged_word[23:16] = wdata_q[7:0];
        default: merged_word[31:24] = wdata_q[7:0];
      endcase
    end else if (funct3_q[1:0] == 2'b01) begin
      if (lane_q[1]) merged_word[31:16] = wdata_q;
      else           merged_word[15:0]  = wdata_q;
    end
  end

  // Memory-side outputs are only changed on the edge that enters a state, so mem_rw is
  // never non-zero outside RD/WR and an async reset drops a pending write immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      we_q         <= 1'b0;
      funct3_q     <= 3'b000;
      lane_q       <= 2'b00;
      wdata_q      <= 16'h0000;
      mem_rw_q     <= 2'b00;
      mem_addr_q   <= '0;
      mem_wdata_q  <= 32'h0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'h0;
      resp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            we_q     <= bus.req_we;
            funct3_q <= bus.req_funct3;
            lane_q   <= req_lane;
            wdata_q  <= bus.req_wdata[15:0];
            if (req_error) begin
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              resp_rdata_q <= 32'h0;
            end else if (bus.req_we && (bus.req_funct3[1:0] == 2'b10)) begin
              state_q     <= WR;
              mem_rw_q    <= 2'b10;
              mem_addr_q  <= req_base;
              mem_wdata_q <= bus.req_wdata;
            end else begin
              state_q    <= RD;
              mem_rw_q   <= 2'b01;
              mem_addr_q <= req_base;
            end
          end
        end
        RD: begin
          if (we_q) begin
            state_q     <= WR;
            mem_rw_q    <= 2'b10;
            mem_wdata_q <= merged_word;
          end else begin
            state_q      <= RESP;
            mem_rw_q     <= 2'b00;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= load_data;
          end
        end
        WR: begin
          state_q      <= RESP;
          mem_rw_q     <= 2'b00;
          resp_valid_q <= 1'b1;
          resp_err_q   <= 1'b0;
          resp_rdata_q <= 32'h0;
        end
        RESP: begin
          if (bus.resp_ready) begin
            state_q      <= IDLE;
            resp_valid_q <= 1'b0;
            mem_rw_q     <= 2'b00;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_dmem_if.sv
// Directed bench for lsu_dmem_if: a byte-level reference model predicts every cycle of each
// transaction, a compare process checks the DUT per cycle, and literal checks pin key results.
module tb_lsu_dmem_if;

  localparam int MEM_BYTES = 80;
  localparam int ADDR_W    = 32;

  typedef struct {
    logic        first;
    logic [1:0]  rw;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        reqReady;
    logic        respValid;
    logic [31:0] rdata;
    logic        err;
  } cycleExp_t;

  logic clk = 1'b0;
  logic rst;

  lsu_dmem_if_if #(.ADDR_W(ADDR_W)) bus ();

  lsu_dmem_if #(.MEM_BYTES(MEM_BYTES), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [7:0]  mem    [MEM_BYTES];
  logic [7:0]  refMem [MEM_BYTES];
  cycleExp_t   expQ[$];
  string       curTag;
  int          checks = 0;
  int          failures = 0;
  int          cycSinceAccept = 0;
  int          obsLatency = 0;
  logic [31:0] lastRdata = 32'h0;
  logic        lastErr = 1'b0;

  function automatic logic [7:0] initByte(input int i);
    if (i == 8) return 8'h64;
    if (i >= 9 && i <= 11) return 8'h00;
    return 8'(i * 7 + 3);
  endfunction

  function automatic logic [31:0] memWord(input int a);
    return {mem[a+3], mem[a+2], mem[a+1], mem[a]};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Behavioural memory: combinational read of four bytes, write committed at the clock edge.
  always_comb begin
    bus.mem_rdata = 32'h0;
    for (int k = 0; k < 4; k++)
      if (longint'(bus.mem_addr) + k < MEM_BYTES)
        bus.mem_rdata[8*k +: 8] = mem[int'(bus.mem_addr) + k];
  end

  initial begin : memProc
    for (int i = 0; i < MEM_BYTES; i++) mem[i] = initByte(i);
    forever begin
      @(posedge clk);
      if (bus.mem_rw == 2'b10)
        for (int k = 0; k < 4; k++)
          if (longint'(bus.mem_addr) + k < MEM_BYTES)
            mem[int'(bus.mem_addr) + k] = bus.mem_wdata[8*k +: 8];
    end
  end

  initial begin : compareProc
    cycleExp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (expQ.size() != 0) begin
          e = expQ.pop_front();
          if (e.first) begin
            cycSinceAccept = 0;
            obsLatency = 0;
          end
          cycSinceAccept++;
          checkOutput({curTag, " mem_rw"}, 32'(bus.mem_rw), 32'(e.rw));
          checkOutput({curTag, " req_ready"}, 32'(bus.req_ready), 32'(e.reqReady));
          checkOutput({curTag, " resp_valid"}, 32'(bus.resp_valid), 32'(e.respValid));
          if (e.rw != 2'b00) checkOutput({curTag, " mem_addr"}, bus.mem_addr, e.addr);
          if (e.rw == 2'b10) checkOutput({curTag, " mem_wdata"}, bus.mem_wdata, e.wdata);
          if (e.respValid) begin
            checkOutput({curTag, " resp_rdata"}, bus.resp_rdata, e.rdata);
            checkOutput({curTag, " resp_err"}, 32'(bus.resp_err), 32'(e.err));
          end
          if (bus.resp_valid === 1'b1) begin
            if (obsLatency == 0) obsLatency = cycSinceAccept;
            lastRdata = bus.resp_rdata;
            lastErr   = bus.resp_err;
          end
        end else begin
          checkOutput("idle mem_rw", 32'(bus.mem_rw), 32'd0);
          checkOutput("idle resp_valid", 32'(bus.resp_valid), 32'd0);
          checkOutput("idle req_ready", 32'(bus.req_ready), 32'd1);
        end
      end
    end
  end

  // Predicts the transaction from byte-level RV32I semantics, then drives it through the DUT.
  task automatic applyStimulus(input string tag, input logic we, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] wdata, input int hold);
    int          size;
    logic        legal;
    logic        misal;
    logic        err;
    logic [31:0] base;
    logic [31:0] loadVal;
    logic [31:0] word;
    int          lat;
    cycleExp_t   e;
    cycleExp_t   pre[$];

    size  = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    legal = we ? (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2)
               : (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
`ifdef LSU_MISALIGN_EN
    base  = addr;
    misal = 1'b0;
`else
    base  = addr - (addr % 4);
    misal = (addr % size) != 0;
`endif
    err = !legal || misal || (longint'(base) + 3 >= MEM_BYTES);
    loadVal = 32'h0;
    word    = 32'h0;
    e = '{first: 1'b0, rw: 2'b00, addr: base, wdata: 32'h0, reqReady: 1'b0,
          respValid: 1'b0, rdata: 32'h0, err: 1'b0};
    if (!err && !we) begin
      for (int k = 0; k < size; k++) loadVal[8*k +: 8] = refMem[int'(addr) + k];
      if (!f3[2] && size < 4 && loadVal[8*size-1]) loadVal = loadVal | (32'hFFFFFFFF << (8*size));
      e.rw = 2'b01;
      pre.push_back(e);
    end else if (!err) begin
      for (int k = 0; k < size; k++) refMem[int'(addr) + k] = wdata[8*k +: 8];
      for (int k = 0; k < 4; k++) word[8*k +: 8] = refMem[int'(base) + k];
      if (size < 4) begin
        e.rw = 2'b01;
        pre.push_back(e);
      end
      e.rw = 2'b10;
      e.wdata = word;
      pre.push_back(e);
    end
    lat = pre.size() + 1;

    @(posedge clk); #1;
    curTag = tag;
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;

    foreach (pre[i]) begin
      e = pre[i];
      e.first = (i == 0);
      expQ.push_back(e);
    end
    for (int i = 0; i <= hold; i++) begin
      e = '{first: (lat == 1 && i == 0), rw: 2'b00, addr: 32'h0, wdata: 32'h0, reqReady: 1'b0,
            respValid: 1'b1, rdata: (err || we) ? 32'h0 : loadVal, err: err};
      expQ.push_back(e);
    end
    e = '{first: 1'b0, rw: 2'b00, addr: 32'h0, wdata: 32'h0, reqReady: 1'b1,
          respValid: 1'b0, rdata: 32'h0, err: 1'b0};
    expQ.push_back(e);

    for (int i = 0; i <= lat - 1 + hold; i++) begin
      bus.resp_ready = (i == lat - 1 + hold);
      @(posedge clk); #1;
    end
    bus.resp_ready = 1'b0;
    for (int t = 0; t < 20 && expQ.size() != 0; t++) @(negedge clk);
    if (expQ.size() != 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s timeout: %0d expected cycles left, required 0", tag, expQ.size());
      expQ.delete();
    end
  endtask

  initial begin : mainProc
    rst = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;
    bus.resp_ready = 1'b0;
    for (int i = 0; i < MEM_BYTES; i++) refMem[i] = initByte(i);
    #1 rst = 1'b1;
    #2;
    checkOutput("reset req_ready", 32'(bus.req_ready), 32'd1);
    checkOutput("reset resp_valid", 32'(bus.resp_valid), 32'd0);
    checkOutput("reset resp_rdata", bus.resp_rdata, 32'h0);
    checkOutput("reset resp_err", 32'(bus.resp_err), 32'd0);
    checkOutput("reset mem_rw", 32'(bus.mem_rw), 32'd0);
    checkOutput("reset mem_addr", bus.mem_addr, 32'h0);
    checkOutput("reset mem_wdata", bus.mem_wdata, 32'h0);
    #10 rst = 1'b0;

    applyStimulus("LW 8", 1'b0, 3'b010, 32'd8, 32'h0, 0);
    checkOutput("LW 8 literal rdata", lastRdata, 32'h00000064);
    checkOutput("LW 8 literal latency", 32'(obsLatency), 32'd2);

    applyStimulus("SW 4", 1'b1, 3'b010, 32'd4, 32'hDEADBEEF, 0);
    checkOutput("SW 4 literal latency", 32'(obsLatency), 32'd2);
    applyStimulus("LW 4", 1'b0, 3'b010, 32'd4, 32'h0, 0);
    checkOutput("LW 4 literal rdata", lastRdata, 32'hDEADBEEF);

    applyStimulus("SB 6", 1'b1, 3'b000, 32'd6, 32'h00000080, 0);
    checkOutput("SB 6 literal latency", 32'(obsLatency), 32'd3);
    checkOutput("SB 6 literal word", memWord(4), 32'hDE80BEEF);
    applyStimulus("LB 6", 1'b0, 3'b000, 32'd6, 32'h0, 0);
    checkOutput("LB 6 literal rdata", lastRdata, 32'hFFFFFF80);
    applyStimulus("LBU 6", 1'b0, 3'b100, 32'd6, 32'h0, 0);
    checkOutput("LBU 6 literal rdata", lastRdata, 32'h00000080);

    applyStimulus("LH 5", 1'b0, 3'b001, 32'd5, 32'h0, 0);
`ifdef LSU_MISALIGN_EN
    checkOutput("LH 5 literal rdata", lastRdata, 32'hFFFF80BE);
    checkOutput("LH 5 literal latency", 32'(obsLatency), 32'd2);
`else
    checkOutput("LH 5 literal err", 32'(lastErr), 32'd1);
    checkOutput("LH 5 literal latency", 32'(obsLatency), 32'd1);
`endif

    applyStimulus("LW 76", 1'b0, 3'b010, 32'd76, 32'h0, 0);
    checkOutput("LW 76 literal rdata", lastRdata, 32'h2C251E17);
    applyStimulus("LW 80", 1'b0, 3'b010, 32'd80, 32'h0, 0);
    checkOutput("LW 80 literal err", 32'(lastErr), 32'd1);
    applyStimulus("LW FFFFFFFC", 1'b0, 3'b010, 32'hFFFFFFFC, 32'h0, 0);
    applyStimulus("funct3 011", 1'b0, 3'b011, 32'd0, 32'h0, 0);
    applyStimulus("SB f3=100", 1'b1, 3'b100, 32'd0, 32'h000000AA, 0);
    checkOutput("SB f3=100 no write", 32'(mem[0]), 32'h03);

    applyStimulus("LH 4 hold", 1'b0, 3'b001, 32'd4, 32'h0, 3);
    checkOutput("LH 4 literal rdata", lastRdata, 32'hFFFFBEEF);
    applyStimulus("SH 10", 1'b1, 3'b001, 32'd10, 32'h1234ABCD, 0);
    checkOutput("SH 10 literal word", memWord(8), 32'hABCD0064);
    applyStimulus("LHU 10", 1'b0, 3'b101, 32'd10, 32'h0, 0);
    checkOutput("LHU 10 literal rdata", lastRdata, 32'h0000ABCD);

    // Abort a store in its write cycle; the memory word must survive.
    @(posedge clk); #1;
    curTag = "rst in WR";
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_funct3 = 3'b010;
    bus.req_addr   = 32'd4;
    bus.req_wdata  = 32'h11223344;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    #1;
    checkOutput("rst in WR mem_rw before", 32'(bus.mem_rw), 32'd2);
    rst = 1'b1;
    #1;
    checkOutput("rst in WR resp_valid", 32'(bus.resp_valid), 32'd0);
    checkOutput("rst in WR req_ready", 32'(bus.req_ready), 32'd1);
    checkOutput("rst in WR mem_rw after", 32'(bus.mem_rw), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk); #1;
    checkOutput("rst in WR word unchanged", memWord(4), 32'hDE80BEEF);
    applyStimulus("LW 4 after rst", 1'b0, 3'b010, 32'd4, 32'h0, 0);
    checkOutput("LW 4 after rst literal", lastRdata, 32'hDE80BEEF);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
